// File: rtl/ita_package.sv
// Shared widths, the GELU constant type and sign-extension helpers for the ITA
// activation datapath.
package ita_package;

  localparam int WI                   = 8;
  localparam int EMS                  = 8;
  localparam int GELU_CONSTANTS_WIDTH = 16;
  localparam int ACC_W                = 48;

  typedef logic signed [GELU_CONSTANTS_WIDTH-1:0] gelu_const_t;

  function automatic logic signed [ACC_W-1:0] sext_const(input gelu_const_t v);
    return {{(ACC_W-GELU_CONSTANTS_WIDTH){v[GELU_CONSTANTS_WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_data(input logic signed [WI-1:0] v);
    return {{(ACC_W-WI){v[WI-1]}}, v};
  endfunction

endpackage

// File: rtl/ita_requant_clip.sv
// Requantizes a wide signed product to int8: multiply, round-half-up arithmetic
// shift, add offset and saturate. Reusable by any ITA activation.
module ita_requant_clip
  import ita_package::*;
(
  input  logic signed [ACC_W-1:0] prod,
  input  logic        [EMS-1:0]   eps_mult,
  input  logic        [EMS-1:0]   right_shift,
  input  logic signed [WI-1:0]    add,
  output logic signed [WI-1:0]    data_o
);

  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-WI+1){1'b0}}, {(WI-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-WI+1){1'b1}}, {(WI-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ONE     = {{(ACC_W-1){1'b0}}, 1'b1};

  logic signed [ACC_W-1:0] multExt;
  logic signed [ACC_W-1:0] scaled;
  logic signed [ACC_W-1:0] roundBit;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] offset;

  // Shifts of ACC_W-1 or more always round to zero because |scaled| < 2^46.
  always_comb begin
    multExt  = {{(ACC_W-EMS){1'b0}}, eps_mult};
    scaled   = prod * multExt;
    roundBit = '0;
    shifted  = scaled;
    if (right_shift >= EMS'(ACC_W-1)) begin
      shifted = '0;
    end else if (right_shift != '0) begin
      roundBit = ONE << (right_shift - 1'b1);
      shifted  = (scaled + roundBit) >>> right_shift;
    end
    offset = shifted + sext_data(add);
    if (offset > OUT_MAX) begin
      data_o = OUT_MAX[WI-1:0];
    end else if (offset < OUT_MIN) begin
      data_o = OUT_MIN[WI-1:0];
    end else begin
      data_o = offset[WI-1:0];
    end
  end

endmodule

// File: rtl/ita_gelu_act.sv
// Integer GELU (I-BERT i-GELU): clipped polynomial erf approximation, product
// with x, then int8 requantization. Purely combinational.
module ita_gelu_act
  import ita_package::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  gelu_const_t           one_i,
  input  gelu_const_t           b_i,
  input  gelu_const_t           c_i,
  input  logic signed [WI-1:0]  data_i,
  input  logic        [EMS-1:0] eps_mult_i,
  input  logic        [EMS-1:0] right_shift_i,
  input  logic signed [WI-1:0]  add_i,
  output logic signed [WI-1:0]  data_o
);

  logic unused_inputs;
  assign unused_inputs = ^{clk_i, rst_ni};

  logic signed [ACC_W-1:0] xExt;
  logic signed [ACC_W-1:0] absX;
  logic signed [ACC_W-1:0] negB;
  logic signed [ACC_W-1:0] clipX;
  logic signed [ACC_W-1:0] diff;
  logic signed [ACC_W-1:0] poly;
  logic signed [ACC_W-1:0] erfL;
  logic signed [ACC_W-1:0] prod;

  // Beyond |x| >= -b the square vanishes and erf saturates to sign*c.
  always_comb begin
    xExt  = sext_data(data_i);
    absX  = data_i[WI-1] ? -xExt : xExt;
    negB  = -sext_const(b_i);
    clipX = (absX < negB) ? absX : negB;
    diff  = clipX + sext_const(b_i);
    poly  = diff * diff + sext_const(c_i);
    erfL  = data_i[WI-1] ? -poly : poly;
    prod  = xExt * (erfL + sext_const(one_i));
  end

  ita_requant_clip u_requant (
    .prod        (prod),
    .eps_mult    (eps_mult_i),
    .right_shift (right_shift_i),
    .add         (add_i),
    .data_o      (data_o)
  );

endmodule

// File: tb/tb_ita_gelu_act.sv
// Directed and exhaustive-x checks of ita_gelu_act against a 64-bit golden model.
`timescale 1ps/1ps
module tb_ita_gelu_act;
  import ita_package::*;

  logic                  clk;
  logic                  rst_n;
  gelu_const_t           one;
  gelu_const_t           b;
  gelu_const_t           c;
  logic signed [WI-1:0]  dataIn;
  logic        [EMS-1:0] epsMult;
  logic        [EMS-1:0] rightShift;
  logic signed [WI-1:0]  addVal;
  logic signed [WI-1:0]  dataOut;

  int assertCount = 0;
  int failCount   = 0;

  ita_gelu_act dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .one_i         (one),
    .b_i           (b),
    .c_i           (c),
    .data_i        (dataIn),
    .eps_mult_i    (epsMult),
    .right_shift_i (rightShift),
    .add_i         (addVal),
    .data_o        (dataOut)
  );

  initial clk = 1'b0;
  always #1000 clk = ~clk;

  function automatic int geluModel(int x, int o, int bb, int cc, int m, int sh, int ad);
    longint a, ac, p, e, g, q, r, s;
    a  = (x < 0) ? -x : x;
    ac = (a < -bb) ? a : -bb;
    p  = (ac + bb) * (ac + bb) + cc;
    e  = (x < 0) ? -p : p;
    g  = longint'(x) * (e + o);
    q  = g * m;
    if (sh == 0) r = q;
    else if (sh >= 62) r = 0;
    else r = (q + (64'sd1 <<< (sh - 1))) >>> sh;
    s = r + ad;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return int'(s);
  endfunction

  task automatic applyStimulus(int o, int bb, int cc, int m, int sh, int ad, int x);
    @(posedge clk);
    #400;
    one        = 16'(o);
    b          = 16'(bb);
    c          = 16'(cc);
    epsMult    = 8'(m);
    rightShift = 8'(sh);
    addVal     = 8'(ad);
    dataIn     = 8'(x);
    #1200;
  endtask

  task automatic checkOutput(string tag, logic signed [WI-1:0] got, int exp);
    assertCount++;
    if (int'(got) != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int o, bb, cc, m, sh, ad;
    rst_n = 1'b0;
    one = '0; b = '0; c = '0; dataIn = '0;
    epsMult = '0; rightShift = '0; addVal = '0;

    applyStimulus(-100, -20, -50, 1, 4, 0, 10);
    checkOutput("reset_track", dataOut, -31);
    rst_n = 1'b1;

    applyStimulus(-100, -20, -50, 1, 4, 0, 10);
    checkOutput("t1_pos_x", dataOut, -31);
    applyStimulus(-100, -20, -50, 1, 4, 0, -10);
    checkOutput("t2_neg_x", dataOut, 94);
    applyStimulus(-100, -20, -50, 1, 4, 0, 30);
    checkOutput("t3_neg_sat", dataOut, -128);
    applyStimulus(-100, -20, -50, 1, 4, 0, -128);
    checkOutput("t4_pos_sat", dataOut, 127);
    applyStimulus(-100, -20, -50, 1, 4, 5, 0);
    checkOutput("t5_zero_x", dataOut, 5);
    applyStimulus(-100, -20, -50, 1, 0, 0, 10);
    checkOutput("t_shift0", dataOut, -128);
    applyStimulus(-100, -20, -50, 1, 200, -7, -128);
    checkOutput("t_bigshift", dataOut, -7);

    for (int a = -128; a <= 127; a++) begin
      applyStimulus(-100, -20, -50, 1, 4, a, 0);
      checkOutput("add_sweep", dataOut, a);
    end

    for (int cfg = 0; cfg < 6; cfg++) begin
      o  = int'($urandom_range(0, 600)) - 300;
      bb = -int'($urandom_range(1, 60));
      cc = int'($urandom_range(0, 1000)) - 500;
      m  = int'($urandom_range(0, 255));
      sh = (cfg < 2) ? 0 : int'($urandom_range(1, 16));
      for (int x = -128; x <= 127; x++) begin
        applyStimulus(o, bb, cc, m, sh, int'($urandom_range(0, 255)) - 128, x);
        checkOutput("exhaustive", dataOut,
                    geluModel(x, o, bb, cc, m, sh, int'(addVal)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
